// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit: opcodes, ALU/mux codes,
// FSM state encoding and the Moore output decode.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_READ,
    ST_MEM_WB,
    ST_MEM_WRITE,
    ST_EXECUTE,
    ST_ALU_WB,
    ST_BRANCH,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       halted;
  } ctrl_t;

  // Pure state decode; FETCH reports its IR/PC strobes as 1 and the top qualifies them
  // with mem_ready.
  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
        c.aluop     = ALUOP_ADD;
      end
      ST_DECODE: begin
        c.alu_src_b = SRC_B_IMM;
        c.aluop     = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_IMM;
        c.aluop     = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRC_B_RS2;
        c.aluop     = ALUOP_FUNC;
      end
      ST_ALU_WB: c.reg_write = 1'b1;
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRC_B_RS2;
        c.aluop         = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      ST_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM of the RV32I core: sequences instruction phases, drives
// datapath strobes and counts retired instructions.
module main_control_fsm
  import riscv_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             illegal_instr,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t           state;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;

  // NOTE: all state lives in this one block and is updated with non-blocking assignments,
  // so every branch reads the pre-edge values of state and retired_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (enable) begin
        case (state)
          ST_IDLE:  state <= ST_FETCH;
          ST_FETCH: if (mem_ready) state <= ST_DECODE;
          ST_DECODE: begin
            if (opcode == OP_LOAD || opcode == OP_STORE) begin
              state <= ST_MEM_ADDR;
            end else if (opcode == OP_RTYPE) begin
              state <= ST_EXECUTE;
            end else if (opcode == OP_BRANCH) begin
              state <= ST_BRANCH;
            end else begin
              illegal_q <= 1'b1;
              state     <= ILLEGAL_HALT ? ST_HALT : ST_FETCH;
            end
          end
          ST_MEM_ADDR: state <= (opcode == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
          ST_MEM_READ: if (mem_ready) state <= ST_MEM_WB;
          ST_MEM_WRITE: begin
            if (mem_ready) begin
              state     <= ST_FETCH;
              retired_q <= retired_q + CNT_W'(1);
            end
          end
          ST_EXECUTE: state <= ST_ALU_WB;
          ST_MEM_WB, ST_ALU_WB, ST_BRANCH: begin
            state     <= ST_FETCH;
            retired_q <= retired_q + CNT_W'(1);
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ctrl_t ctrl;

  // NOTE: ctrl is fully assigned before any conditional override, so no latch is inferred.
  always_comb begin
    ctrl = decode_state(state);
    if (state == ST_FETCH) begin
      ctrl.ir_write = mem_ready;
      ctrl.pc_write = mem_ready;
    end
    // A frozen core must not commit anything; read requests and mux selects stay put.
    if (!enable) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.mem_write     = 1'b0;
    end
    if (!reset) ctrl = '0;
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign aluop         = ctrl.aluop;
  assign halted        = ctrl.halted;
  assign illegal_instr = reset & illegal_q;
  assign retired       = reset ? retired_q : '0;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized scoreboard bench: an instruction-level model predicts every cycle's outputs for
// two instances (illegal opcode resumes / halts), a monitor compares on the falling edge.
module tb_main_control_fsm;
  import riscv_pkg::*;

  localparam int CNT_W = 4;
  localparam int NCYC  = 4000;

  typedef logic [19:0] vec_t;

  // One micro-step of an instruction: which strobes it raises and whether it waits on memory.
  typedef struct packed {
    bit         pw, pwc, ps, iord, mr, mw, irw, m2r, rw, sa;
    logic [1:0] sb, aop;
    bit         wt;
  } uop_t;

  logic clk = 1'b0;
  logic reset, enable, mem_ready;
  logic [6:0] op0, op1;

  logic o0_pw, o0_pwc, o0_ps, o0_iord, o0_mr, o0_mw, o0_irw, o0_m2r, o0_rw, o0_sa, o0_ill, o0_halt;
  logic o1_pw, o1_pwc, o1_ps, o1_iord, o1_mr, o1_mw, o1_irw, o1_m2r, o1_rw, o1_sa, o1_ill, o1_halt;
  logic [1:0] o0_sb, o0_aop, o1_sb, o1_aop;
  logic [CNT_W-1:0] o0_ret, o1_ret;

  always #5 clk = ~clk;

  main_control_fsm #(.CNT_W(CNT_W), .ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .opcode(op0), .mem_ready(mem_ready),
    .pc_write(o0_pw), .pc_write_cond(o0_pwc), .pc_source(o0_ps), .iord(o0_iord),
    .mem_read(o0_mr), .mem_write(o0_mw), .ir_write(o0_irw), .mem_to_reg(o0_m2r),
    .reg_write(o0_rw), .alu_src_a(o0_sa), .alu_src_b(o0_sb), .aluop(o0_aop),
    .illegal_instr(o0_ill), .halted(o0_halt), .retired(o0_ret)
  );

  main_control_fsm #(.CNT_W(CNT_W), .ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .opcode(op1), .mem_ready(mem_ready),
    .pc_write(o1_pw), .pc_write_cond(o1_pwc), .pc_source(o1_ps), .iord(o1_iord),
    .mem_read(o1_mr), .mem_write(o1_mw), .ir_write(o1_irw), .mem_to_reg(o1_m2r),
    .reg_write(o1_rw), .alu_src_a(o1_sa), .alu_src_b(o1_sb), .aluop(o1_aop),
    .illegal_instr(o1_ill), .halted(o1_halt), .retired(o1_ret)
  );

  vec_t act0, act1;
  assign act0 = {o0_pw, o0_pwc, o0_ps, o0_iord, o0_mr, o0_mw, o0_irw, o0_m2r, o0_rw, o0_sa,
                 o0_sb, o0_aop, o0_ill, o0_halt, o0_ret};
  assign act1 = {o1_pw, o1_pwc, o1_ps, o1_iord, o1_mr, o1_mw, o1_irw, o1_m2r, o1_rw, o1_sa,
                 o1_sb, o1_aop, o1_ill, o1_halt, o1_ret};

  // Reference model: mode 0 idle / 1 running / 2 halted; kind 0 lw, 1 sw, 2 R, 3 beq;
  // pos is the micro-step within the instruction (0 fetch, 1 decode, 2.. body).
  int mode[2], kind[2], pos[2], cnt[2];
  bit ill[2];
  vec_t exp0_q[$], exp1_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic int instr_len(input int k);
    case (k)
      0:       return 5;
      3:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic uop_t uop(input int k, input int p);
    uop_t u;
    u = '0;
    if (p == 0) begin
      u.mr = 1; u.pw = 1; u.irw = 1; u.sb = 2'b01; u.wt = 1;
    end else if (p == 1) begin
      u.sb = 2'b10;
    end else begin
      case (k)
        0: if (p == 2) begin u.sa = 1; u.sb = 2'b10; end
           else if (p == 3) begin u.mr = 1; u.iord = 1; u.wt = 1; end
           else begin u.rw = 1; u.m2r = 1; end
        1: if (p == 2) begin u.sa = 1; u.sb = 2'b10; end
           else begin u.mw = 1; u.iord = 1; u.wt = 1; end
        2: if (p == 2) begin u.sa = 1; u.sb = 2'b00; u.aop = 2'b10; end
           else u.rw = 1;
        default: begin u.sa = 1; u.sb = 2'b00; u.aop = 2'b01; u.pwc = 1; u.ps = 1; end
      endcase
    end
    return u;
  endfunction

  function automatic int kind_of(input logic [6:0] op);
    if (op == 7'b0000011) return 0;
    if (op == 7'b0100011) return 1;
    if (op == 7'b0110011) return 2;
    if (op == 7'b1100011) return 3;
    return -1;
  endfunction

  function automatic vec_t expect_vec(input int m);
    uop_t u;
    if (!reset) return '0;
    u = '0;
    if (mode[m] == 1) u = uop(kind[m], pos[m]);
    if (mode[m] == 1 && pos[m] == 0) begin
      u.pw  = u.pw & mem_ready;
      u.irw = u.irw & mem_ready;
    end
    if (!enable) begin
      u.pw = 0; u.pwc = 0; u.irw = 0; u.rw = 0; u.mw = 0;
    end
    return {u.pw, u.pwc, u.ps, u.iord, u.mr, u.mw, u.irw, u.m2r, u.rw, u.sa, u.sb, u.aop,
            ill[m], (mode[m] == 2), CNT_W'(cnt[m])};
  endfunction

  task automatic advance(input int m, input logic [6:0] op);
    uop_t u;
    int   k;
    if (!reset) begin
      mode[m] = 0; pos[m] = 0; cnt[m] = 0; ill[m] = 0;
      return;
    end
    ill[m] = 0;
    if (!enable) return;
    if (mode[m] == 0) begin
      mode[m] = 1; pos[m] = 0;
    end else if (mode[m] == 1) begin
      u = uop(kind[m], pos[m]);
      if (u.wt && !mem_ready) return;
      if (pos[m] == 1) begin
        k = kind_of(op);
        if (k < 0) begin
          ill[m] = 1;
          if (m == 1) mode[m] = 2;
          else pos[m] = 0;
        end else begin
          kind[m] = k;
          pos[m]  = 2;
        end
      end else if (pos[m] == instr_len(kind[m]) - 1) begin
        cnt[m] = (cnt[m] + 1) % (1 << CNT_W);
        pos[m] = 0;
      end else begin
        pos[m]++;
      end
    end
  endtask

  function automatic logic [6:0] pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 22) return 7'b0000011;
    if (r < 44) return 7'b0100011;
    if (r < 66) return 7'b0110011;
    if (r < 88) return 7'b1100011;
    if (r < 94) return 7'b0010011;
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    else
      n_pass++;
  endtask

  // Monitor: compares whatever the scoreboard predicted for the cycle just driven.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        check("dut0_outputs", act0, e);
      end
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        check("dut1_outputs", act1, e);
      end
    end
  end

  // Driver: random inputs each cycle, prediction pushed before the model steps across the edge.
  initial begin
    int rst_left;
    reset = 1'b0; enable = 1'b0; mem_ready = 1'b0; op0 = '0; op1 = '0;
    rst_left = 0;
    for (int m = 0; m < 2; m++) begin
      mode[m] = 0; kind[m] = 0; pos[m] = 0; cnt[m] = 0; ill[m] = 0;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      if (c < 3) begin
        reset = 1'b0;
      end else if (rst_left > 0) begin
        reset = 1'b0;
        rst_left--;
      end else if ($urandom_range(0, 199) < 3) begin
        reset    = 1'b0;
        rst_left = $urandom_range(0, 2);
      end else begin
        reset = 1'b1;
      end
      enable    = ($urandom_range(0, 99) >= 15);
      mem_ready = ($urandom_range(0, 99) < 55);
      if (mode[0] != 1 || pos[0] == 0) op0 = pick_op();
      if (mode[1] != 1 || pos[1] == 0) op1 = pick_op();
      exp0_q.push_back(expect_vec(0));
      exp1_q.push_back(expect_vec(1));
      advance(0, op0);
      advance(1, op1);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
